// File: rtl/comparator_seq_nbits.sv
// Sequential multi-mode comparator: walks the operands CHUNK bits per cycle,
// MSB chunk first, and stops at the first chunk that differs.
module comparator_seq_nbits #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             s,
    output logic             eq,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_next;
    logic [KW-1:0]    k, k_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [2:0]       mode_reg;
    logic             signed_reg;
    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic             busy_next, done_next, s_next, eq_next, lt_next;
    logic             load, advance;

    function automatic logic select_rel(input logic [2:0] m, input logic e, input logic l);
        case (m)
            3'b000:  return e;
            3'b001:  return ~e;
            3'b010:  return l;
            3'b011:  return l | e;
            3'b100:  return ~l & ~e;
            3'b101:  return ~l;
            default: return 1'b0;
        endcase
    endfunction

    // Operands shift left as chunks match, so the chunk under test is always the top one.
    // Flipping the sign bit of the MSB chunk turns a two's-complement compare into unsigned.
    always_comb begin
        chunk_a = a_reg[WIDTH-1 -: CHUNK];
        chunk_b = b_reg[WIDTH-1 -: CHUNK];
        if (signed_reg && (k == '0)) begin
            chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
            chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
        end
    end

    always_comb begin
        state_next = state;
        k_next     = k;
        busy_next  = busy;
        done_next  = 1'b0;
        s_next     = s;
        eq_next    = eq;
        lt_next    = lt;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    k_next     = '0;
                    busy_next  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (chunk_a != chunk_b) begin
                    lt_next    = (chunk_a < chunk_b);
                    eq_next    = 1'b0;
                    s_next     = select_rel(mode_reg, 1'b0, chunk_a < chunk_b);
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else if (k == KW'(NCHUNK - 1)) begin
                    lt_next    = 1'b0;
                    eq_next    = 1'b1;
                    s_next     = select_rel(mode_reg, 1'b1, 1'b0);
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    k_next  = k + KW'(1);
                    advance = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            state <= state_next;
            k     <= k_next;
            busy  <= busy_next;
            done  <= done_next;
            s     <= s_next;
            eq    <= eq_next;
            lt    <= lt_next;
        end
    end

    // Captured operands carry no reset: they are only read while in BUSY.
    always_ff @(posedge clk) begin
        if (load) begin
            a_reg      <= a;
            b_reg      <= b;
            mode_reg   <= mode;
            signed_reg <= is_signed;
        end else if (advance) begin
            a_reg <= a_reg << CHUNK;
            b_reg <= b_reg << CHUNK;
        end
    end

endmodule

// File: tb/tb_comparator_seq_nbits.sv
// Scoreboard bench for comparator_seq_nbits: arithmetic reference model feeds
// an expectation queue that a monitor drains on every done pulse.
module tb_comparator_seq_nbits;

    localparam int WIDTH  = 16;
    parameter  int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       mode;
    logic             is_signed;
    logic             busy, done, s, eq, lt;

    typedef struct {
        logic s;
        logic eq;
        logic lt;
        int   due;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   busy_end = 0;
    int   checks   = 0;
    int   errors   = 0;
    logic hold_s   = 1'b0;
    logic hold_eq  = 1'b0;
    logic hold_lt  = 1'b0;

    comparator_seq_nbits #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .mode(mode),
        .is_signed(is_signed), .busy(busy), .done(done), .s(s), .eq(eq), .lt(lt)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: relation from plain integer compares; latency from the
    // position of the most significant differing bit.
    function automatic void predict(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic [2:0] m, input logic sg,
                                    output logic rs, output logic req, output logic rlt,
                                    output int lat);
        logic [WIDTH-1:0] diff;
        logic             gt;
        int               top;
        req = (x == y);
        rlt = sg ? ($signed(x) < $signed(y)) : (x < y);
        gt  = sg ? ($signed(x) > $signed(y)) : (x > y);
        case (m)
            3'd0:    rs = (x == y);
            3'd1:    rs = (x != y);
            3'd2:    rs = rlt;
            3'd3:    rs = !gt;
            3'd4:    rs = gt;
            3'd5:    rs = !rlt;
            default: rs = 1'b0;
        endcase
        diff = x ^ y;
        top  = -1;
        for (int i = 0; i < WIDTH; i++) if (diff[i]) top = i;
        lat = (top < 0) ? NCHUNK : (WIDTH - 1 - top) / CHUNK + 1;
    endfunction

    // Model: accepts a request on any edge where the previous op has finished.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                busy_end = cyc;
            end else if (start && cyc > busy_end) begin
                predict(a, b, mode, is_signed, e.s, e.eq, e.lt, lat);
                e.due    = cyc + lat;
                busy_end = cyc + lat;
                q.push_back(e);
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chki("reset_outputs", int'({busy, done, s, eq, lt}), 0);
                hold_s  = 1'b0;
                hold_eq = 1'b0;
                hold_lt = 1'b0;
            end else begin
                chk1("busy", busy, cyc < busy_end);
                if (done) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected no pending op at cycle %0d", cyc);
                    end else begin
                        e = q.pop_front();
                        chki("done_cycle", cyc, e.due);
                        chk1("s", s, e.s);
                        chk1("eq", eq, e.eq);
                        chk1("lt", lt, e.lt);
                        hold_s  = e.s;
                        hold_eq = e.eq;
                        hold_lt = e.lt;
                    end
                end else begin
                    if (q.size() != 0 && q[0].due < cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL missing_done: got done=0 expected done at cycle %0d", q[0].due);
                        void'(q.pop_front());
                    end
                    chk1("hold_s", s, hold_s);
                    chk1("hold_eq", eq, hold_eq);
                    chk1("hold_lt", lt, hold_lt);
                end
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [2:0] m, input logic sg);
        a         = x;
        b         = y;
        mode      = m;
        is_signed = sg;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cyc < busy_end && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (cyc < busy_end) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy at cycle %0d expected idle by cycle %0d", cyc, busy_end);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] msk;
        int               n;
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        mode      = '0;
        is_signed = 1'b0;

        @(negedge clk);
        start     = 1'b1;
        a         = WIDTH'($urandom);
        b         = WIDTH'($urandom);
        mode      = 3'($urandom_range(0, 7));
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;

        issue(16'h00FF, 16'h00FF, 3'b000, 1'b0); wait_idle();
        issue(16'h00FF, 16'h00FF, 3'b001, 1'b0); wait_idle();
        issue(16'h1234, 16'h2234, 3'b010, 1'b0); wait_idle();
        issue(16'h1235, 16'h1234, 3'b101, 1'b0); wait_idle();
        issue(16'hFFFF, 16'h0001, 3'b100, 1'b1); wait_idle();
        issue(16'hFFFF, 16'h0001, 3'b100, 1'b0); wait_idle();

        // Inputs and start changing mid-operation must be ignored.
        issue(16'h1234, 16'h1230, 3'b011, 1'b0);
        a     = 16'h0000;
        mode  = 3'b000;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cyc < busy_end && n < 64) begin
            @(negedge clk);
            n++;
        end
        // Now in the done cycle: a new request is accepted on the next edge.
        issue(16'hABCD, 16'hABCD, 3'b000, 1'b0); wait_idle();

        // Reset two cycles into an equal-operand compare.
        issue(16'h5555, 16'h5555, 3'b000, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chki("async_reset_clear", int'({busy, done, s, eq, lt}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (NCHUNK + 4) @(negedge clk);

        issue(16'h2468, 16'h2468, 3'b110, 1'b0); wait_idle();
        issue(16'h0001, 16'h8000, 3'b111, 1'b1); wait_idle();

        for (int i = 0; i < 500; i++) begin
            a         = WIDTH'($urandom);
            msk       = WIDTH'($urandom_range(1, (1 << CHUNK) - 1)) << (CHUNK * $urandom_range(0, NCHUNK - 1));
            case ($urandom_range(0, 2))
                0:       b = WIDTH'($urandom);
                1:       b = a;
                default: b = a ^ msk;
            endcase
            mode      = 3'($urandom_range(0, 7));
            is_signed = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        start = 1'b0;

        n = 0;
        while (q.size() != 0 && n < NCHUNK + 8) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending ops expected 0", q.size());
        end
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
